parity_frame_checker: RTL and testbench
=======================================

# parity_frame_checker

Streaming parity checker. Applies the parity reduction (even = XOR, odd = XNOR seeded with 1) to every accepted data beat and compares it against the beat's transmitted parity bit. It accumulates per-frame error and beat counts and a whole-frame parity, then presents one result record per frame through a valid/ready output register. It sits between a word-serial receive path and the link-status logic, and replaces single-word combinational parity reduction wherever framing and backpressure exist.

## Interface
- DATA_WIDTH, 8, bits per data beat (≥1)
- MAX_FRAME_LEN, 16, maximum beats counted per frame (≥1); CW = $clog2(MAX_FRAME_LEN+1)
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- inputValid  input  1  beat present
- inputReady  output  1  beat accepted when inputValid && inputReady
- inputData  input  DATA_WIDTH  beat payload
- inputParity  input  1  transmitted parity bit for inputData
- inputLast  input  1  final beat of frame
- inputMode  input  1  0 = even (XOR), 1 = odd (XNOR); sampled on first beat of frame only
- outputValid  output  1  result record valid
- outputReady  input  1  consumer takes record when outputValid && outputReady
- outputErrorCount  output  CW  beats whose parity mismatched
- outputBeatCount  output  CW  beats accepted in frame
- outputFrameParity  output  1  mode reduction over every data bit of the frame
- outputLengthError  output  1  frame exceeded MAX_FRAME_LEN beats
- outputError  output  1  (outputErrorCount != 0) || outputLengthError

## Operation
- States: IDLE (no frame open), ACTIVE (frame open). Output register is independent of the state.
- inputReady = !outputValid || outputReady (combinational). Beats are accepted in either state.
- Beat parity p = ^inputData in even mode, ~^inputData in odd mode. Mismatch when p != inputParity.
- Accepted beat in IDLE:
  - latch inputMode as frameMode.
  - beat count ← 1; error count ← mismatch.
  - frame accumulator ← ^inputData.
  - go ACTIVE, unless inputLast is set.
- Accepted beat in ACTIVE:
  - mismatch uses frameMode; inputMode is ignored.
  - beat count increments, saturating at MAX_FRAME_LEN. Any beat accepted while the count already equals MAX_FRAME_LEN sets the sticky lengthError.
  - error count increments on mismatch, saturating at MAX_FRAME_LEN.
  - accumulator ^= ^inputData.
- Accepted beat with inputLast, in either state:
  - load the output register with the final counts (including this beat), lengthError, and frameParity (accumulator in even mode, inverted accumulator in odd mode).
  - set outputValid and return to IDLE. Internal counters clear for the next frame.
- outputValid clears on outputReady unless a new last beat is accepted in the same cycle; in that case the register reloads and outputValid stays 1.
- Beats accepted when inputValid is low: none. Ignored inputs do not change state.
- Reset mid-frame: the frame is discarded and no record is emitted.

## Timing
- Reset values:
  - outputValid 0; all output fields 0; state IDLE.
  - inputReady 1.
- Latency: record appears in the cycle after the clock edge that accepts the last beat (1 cycle).
- Throughput: one beat per cycle sustained while outputReady = 1, including back-to-back single-beat frames.
- Backpressure: with outputValid = 1 and outputReady = 0, inputReady = 0. No beat is accepted and the record holds stable.
- The cycle outputReady rises, a beat (including a last beat) is accepted in the same cycle.
- Output fields change only on record load; they are stable while outputValid = 1.

## Test plan
- DATA_WIDTH 8, MAX 4, even mode. Beats 0x01/p1, 0x03/p0, 0xFF/p0(last) with outputReady 1. Next cycle: outputValid 1, beatCount 3, errorCount 0, frameParity 1, outputError 0.
- Odd mode, single beat 0x00/p0/last. Next cycle: errorCount 1, beatCount 1, frameParity 1, outputError 1. Then drive inputMode 0 mid-way through a following odd frame and check the frame is still judged odd.
- MAX 4, 6 beats all parity-correct, last on beat 6. Record: beatCount 4, lengthError 1, errorCount 0, outputError 1.
- Hold outputReady 0 after a record and present a new frame. inputReady 0 and the record is held unchanged. Raise outputReady: the beat is accepted that cycle. Back-to-back single-beat last frames produce one record per cycle.
- Assert reset after 2 beats of a frame. All outputs 0, inputReady 1. A subsequent 1-beat frame reports beatCount 1, with no residue from the aborted frame.

Source files
------------

// File: rtl/parity_frame_checker_if.sv
// rtl/parity_frame_checker_if.sv - beat input and result record handshakes for parity_frame_checker
interface parity_frame_checker_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_FRAME_LEN = 16
);
    localparam int CW = $clog2(MAX_FRAME_LEN + 1);

    logic                  inputValid;
    logic                  inputReady;
    logic [DATA_WIDTH-1:0] inputData;
    logic                  inputParity;
    logic                  inputLast;
    logic                  inputMode;

    logic                  outputValid;
    logic                  outputReady;
    logic [CW-1:0]         outputErrorCount;
    logic [CW-1:0]         outputBeatCount;
    logic                  outputFrameParity;
    logic                  outputLengthError;
    logic                  outputError;

    modport master (
        output inputValid, inputData, inputParity, inputLast, inputMode, outputReady,
        input  inputReady, outputValid, outputErrorCount, outputBeatCount,
               outputFrameParity, outputLengthError, outputError
    );

    modport slave (
        input  inputValid, inputData, inputParity, inputLast, inputMode, outputReady,
        output inputReady, outputValid, outputErrorCount, outputBeatCount,
               outputFrameParity, outputLengthError, outputError
    );
endinterface

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - per-beat parity check with per-frame result records
module parity_frame_checker #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_FRAME_LEN = 16
) (
    input logic                  clk,
    input logic                  rst,
    parity_frame_checker_if.slave bus
);
    localparam int              CW      = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_FRAME_LEN);
    localparam logic [0:0]      IDLE    = 1'b0;
    localparam logic [0:0]      ACTIVE  = 1'b1;

    logic [0:0]    state;
    logic          frame_mode;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] err_cnt;
    logic          acc;
    logic          len_err;

    logic          accept;
    logic          mode_eff;
    logic          beat_red;
    logic          mismatch;
    logic [CW-1:0] beat_nxt;
    logic [CW-1:0] err_nxt;
    logic          acc_nxt;
    logic          len_nxt;

    assign bus.inputReady = !bus.outputValid || bus.outputReady;
    assign accept         = bus.inputValid && bus.inputReady;

    // Mode is taken from the first beat; later beats use the latched frame mode.
    assign mode_eff = (state == IDLE) ? bus.inputMode : frame_mode;
    assign beat_red = ^bus.inputData;
    assign mismatch = (beat_red ^ mode_eff) != bus.inputParity;

    always_comb begin
        beat_nxt = CW'(1);
        err_nxt  = CW'(mismatch);
        acc_nxt  = beat_red;
        len_nxt  = 1'b0;
        if (state == ACTIVE) begin
            beat_nxt = (beat_cnt == MAX_CNT) ? MAX_CNT : beat_cnt + CW'(1);
            err_nxt  = (err_cnt == MAX_CNT) ? MAX_CNT : err_cnt + CW'(mismatch);
            acc_nxt  = acc ^ beat_red;
            len_nxt  = len_err || (beat_cnt == MAX_CNT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frame_mode <= 1'b0;
            beat_cnt   <= '0;
            err_cnt    <= '0;
            acc        <= 1'b0;
            len_err    <= 1'b0;
        end else if (accept) begin
            if (bus.inputLast) begin
                state      <= IDLE;
                frame_mode <= 1'b0;
                beat_cnt   <= '0;
                err_cnt    <= '0;
                acc        <= 1'b0;
                len_err    <= 1'b0;
            end else begin
                state      <= ACTIVE;
                frame_mode <= mode_eff;
                beat_cnt   <= beat_nxt;
                err_cnt    <= err_nxt;
                acc        <= acc_nxt;
                len_err    <= len_nxt;
            end
        end
    end

    // A last beat accepted while the consumer drains reloads the record and keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.outputValid       <= 1'b0;
            bus.outputBeatCount   <= '0;
            bus.outputErrorCount  <= '0;
            bus.outputLengthError <= 1'b0;
            bus.outputFrameParity <= 1'b0;
        end else if (accept && bus.inputLast) begin
            bus.outputValid       <= 1'b1;
            bus.outputBeatCount   <= beat_nxt;
            bus.outputErrorCount  <= err_nxt;
            bus.outputLengthError <= len_nxt;
            bus.outputFrameParity <= acc_nxt ^ mode_eff;
        end else if (bus.outputReady) begin
            bus.outputValid <= 1'b0;
        end
    end

    assign bus.outputError = (bus.outputErrorCount != '0) || bus.outputLengthError;
endmodule

// File: tb/tb_parity_frame_checker.sv
// tb/tb_parity_frame_checker.sv - directed and random stimulus against a frame-level reference model
module tb_parity_frame_checker;
    localparam int DW   = 8;
    localparam int MAXL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parity_frame_checker_if #(.DATA_WIDTH(DW), .MAX_FRAME_LEN(MAXL)) bus ();
    parity_frame_checker #(.DATA_WIDTH(DW), .MAX_FRAME_LEN(MAXL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q_data[$];
    bit            q_par[$];
    bit            fmode;
    bit            exp_ov;
    int            exp_bc, exp_ec;
    bit            exp_le, exp_fp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int par_of(input logic [DW-1:0] d, input bit m);
        return ($countones(d) + int'(m)) % 2;
    endfunction

    task automatic finish_frame();
        int n, nerr, ones;
        n = q_data.size();
        nerr = 0;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            if (par_of(q_data[i], fmode) != int'(q_par[i])) nerr++;
            ones += $countones(q_data[i]);
        end
        exp_bc = (n < MAXL) ? n : MAXL;
        exp_ec = (nerr < MAXL) ? nerr : MAXL;
        exp_le = (n > MAXL);
        exp_fp = ((ones + int'(fmode)) % 2) == 1;
        q_data.delete();
        q_par.delete();
    endtask

    task automatic check_out();
        chk("output_valid",  bus.outputValid,       exp_ov);
        chk("beat_count",    bus.outputBeatCount,   exp_bc);
        chk("error_count",   bus.outputErrorCount,  exp_ec);
        chk("length_error",  bus.outputLengthError, exp_le);
        chk("frame_parity",  bus.outputFrameParity, exp_fp);
        chk("output_error",  bus.outputError,       (exp_ec != 0) || exp_le);
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit p,
                        input bit last, input bit m, input bit ordy);
        bit acc_b;
        bus.inputValid  = v;
        bus.inputData   = d;
        bus.inputParity = p;
        bus.inputLast   = last;
        bus.inputMode   = m;
        bus.outputReady = ordy;
        #1;
        chk("input_ready", bus.inputReady, !exp_ov || ordy);
        acc_b = v && (!exp_ov || ordy);
        @(posedge clk);
        #1;
        if (acc_b) begin
            if (q_data.size() == 0) fmode = m;
            q_data.push_back(d);
            q_par.push_back(p);
        end
        if (acc_b && last) begin
            finish_frame();
            exp_ov = 1'b1;
        end else if (ordy) begin
            exp_ov = 1'b0;
        end
        check_out();
    endtask

    task automatic do_reset();
        bus.inputValid  = 1'b0;
        bus.outputReady = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #2;
        q_data.delete();
        q_par.delete();
        exp_ov = 0; exp_bc = 0; exp_ec = 0; exp_le = 0; exp_fp = 0;
        check_out();
        chk("reset_input_ready", bus.inputReady, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        rst = 1'b1;
        bus.inputValid = 0; bus.inputData = '0; bus.inputParity = 0;
        bus.inputLast = 0; bus.inputMode = 0; bus.outputReady = 0;
        exp_ov = 0; exp_bc = 0; exp_ec = 0; exp_le = 0; exp_fp = 0;
        repeat (2) @(posedge clk);
        #1;
        check_out();
        chk("reset_input_ready", bus.inputReady, 1);
        rst = 1'b0;

        // Even frame of three correct beats
        step(1, 8'h01, 1, 0, 0, 1);
        step(1, 8'h03, 0, 0, 0, 1);
        step(1, 8'hFF, 0, 1, 0, 1);
        chk("t1_valid", bus.outputValid, 1);
        chk("t1_beats", bus.outputBeatCount, 3);
        chk("t1_errs",  bus.outputErrorCount, 0);
        chk("t1_fpar",  bus.outputFrameParity, 1);
        chk("t1_err",   bus.outputError, 0);

        // Odd single-beat mismatch, then mode change mid-frame is ignored
        step(1, 8'h00, 0, 1, 1, 1);
        chk("t2_errs",  bus.outputErrorCount, 1);
        chk("t2_beats", bus.outputBeatCount, 1);
        chk("t2_fpar",  bus.outputFrameParity, 1);
        chk("t2_err",   bus.outputError, 1);
        step(1, 8'h03, 1, 0, 1, 1);
        step(1, 8'h01, 0, 1, 0, 1);
        chk("t2b_errs", bus.outputErrorCount, 0);
        chk("t2b_fpar", bus.outputFrameParity, 0);

        // Over-length frame of six correct even beats
        for (int i = 1; i <= 6; i++) begin
            d = DW'(i);
            step(1, d, bit'($countones(d) % 2), i == 6, 0, 1);
        end
        chk("t3_beats",  bus.outputBeatCount, 4);
        chk("t3_lenerr", bus.outputLengthError, 1);
        chk("t3_errs",   bus.outputErrorCount, 0);
        chk("t3_err",    bus.outputError, 1);

        // Backpressure holds the record, release accepts in the same cycle
        step(1, 8'h05, 0, 1, 0, 0);
        chk("t4_blocked", bus.inputReady, 0);
        step(1, 8'h05, 0, 1, 0, 0);
        step(1, 8'h07, 1, 1, 0, 1);
        chk("t4_beats", bus.outputBeatCount, 1);
        chk("t4_errs",  bus.outputErrorCount, 0);
        chk("t4_fpar",  bus.outputFrameParity, 1);
        for (int i = 0; i < 4; i++) begin
            d = DW'($urandom);
            step(1, d, bit'($countones(d) % 2), 1, 0, 1);
        end

        // Reset mid-frame discards the partial frame
        step(1, 8'h11, 1, 0, 0, 1);
        step(1, 8'h22, 1, 0, 0, 1);
        do_reset();
        step(1, 8'h80, 1, 1, 0, 1);
        chk("t5_beats", bus.outputBeatCount, 1);
        chk("t5_errs",  bus.outputErrorCount, 0);
        step(0, 8'h00, 0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, DW'($urandom), bit'($urandom % 2),
                 ($urandom % 4) == 0, bit'($urandom % 2), ($urandom % 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
